// File: rtl/int_sched.sv
// Interrupt/reset service sequencer: detects NMI edges and IRQ levels, then
// steps through the seven-cycle push/vector sequence.
module int_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       sync,
    input  logic       brk_op,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       i_flag,
    output logic       svc_active,
    output logic [2:0] svc_cyc,
    output logic [7:0] vec_adl,
    output logic       vec_fetch,
    output logic       wr_inhibit,
    output logic       ipc_inhibit,
    output logic       b_flag,
    output logic       set_i,
    output logic       force_brk,
    output logic       nmi_pend
);

    typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_SERVICE} state_t;
    typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

    state_t     state;
    src_t       src;
    logic [2:0] cyc;
    logic       nmi_q;
    logic       pend;
    logic       nmi_late;
    logic       nmi_edge;
    logic       irq_req;
    logic       take;

    assign nmi_edge  = nmi_q & ~nmi_n;
    assign irq_req   = ~irq_n & ~i_flag;
    assign take      = (state == ST_IDLE) & sync & (pend | irq_req);
    assign force_brk = take & rdy;
    assign nmi_pend  = pend;
    assign svc_cyc   = cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RESET;
            src      <= SRC_RST;
            cyc      <= '0;
            pend     <= 1'b0;
            nmi_q    <= 1'b1;
            nmi_late <= 1'b0;
        end else if (rdy) begin
            nmi_q <= nmi_n;
            if (nmi_edge)
                pend <= 1'b1;
            case (state)
                ST_RESET: begin
                    state <= ST_SERVICE;
                    cyc   <= '0;
                    src   <= SRC_RST;
                end
                ST_IDLE: begin
                    if (take) begin
                        state <= ST_SERVICE;
                        cyc   <= '0;
                        src   <= pend ? SRC_NMI : SRC_IRQ;
                    end else if (brk_op) begin
                        state <= ST_SERVICE;
                        cyc   <= 3'd1;
                        src   <= SRC_BRK;
                    end
                end
                ST_SERVICE: begin
                    if (cyc == 3'd4 && pend && (src == SRC_IRQ || src == SRC_BRK))
                        src <= SRC_NMI;
                    // an edge in cycle 5 must survive the end-of-service clear
                    if (cyc == 3'd5 && nmi_edge)
                        nmi_late <= 1'b1;
                    if (cyc == 3'd6) begin
                        state    <= ST_IDLE;
                        cyc      <= '0;
                        nmi_late <= 1'b0;
                        if (src == SRC_NMI)
                            pend <= nmi_edge | nmi_late;
                    end else begin
                        cyc <= cyc + 3'd1;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        svc_active  = (state != ST_IDLE);
        ipc_inhibit = svc_active && (cyc <= 3'd1) && (src != SRC_BRK);
        wr_inhibit  = (state == ST_SERVICE) && (cyc >= 3'd2) && (cyc <= 3'd4) && (src == SRC_RST);
        b_flag      = (state == ST_SERVICE) && (cyc == 3'd4) && (src == SRC_BRK);
        set_i       = (state == ST_SERVICE) && (cyc == 3'd5);
        vec_fetch   = (state == ST_SERVICE) && (cyc >= 3'd5);
        vec_adl     = '0;
        if (vec_fetch) begin
            case (src)
                SRC_NMI: vec_adl = 8'hFA;
                SRC_RST: vec_adl = 8'hFC;
                default: vec_adl = 8'hFE;
            endcase
            vec_adl[0] = (cyc == 3'd6);
        end
    end

endmodule

// File: tb/tb_int_sched.sv
// Randomized directed bench for int_sched against a cycle-role table model.
module tb_int_sched;

    logic       clk = 1'b0;
    logic       rst, rdy, sync, brk_op, irq_n, nmi_n, i_flag;
    logic       svc_active, vec_fetch, wr_inhibit, ipc_inhibit, b_flag, set_i, force_brk, nmi_pend;
    logic [2:0] svc_cyc;
    logic [7:0] vec_adl;

    localparam int S_RST = 0, S_NMI = 1, S_IRQ = 2, S_BRK = 3;
    localparam logic [7:0] VEC_LO [4] = '{8'hFC, 8'hFA, 8'hFE, 8'hFE};

    int checks = 0;
    int failures = 0;
    bit pend_m = 1'b0;

    int_sched dut (
        .clk(clk), .rst(rst), .rdy(rdy), .sync(sync), .brk_op(brk_op),
        .irq_n(irq_n), .nmi_n(nmi_n), .i_flag(i_flag),
        .svc_active(svc_active), .svc_cyc(svc_cyc), .vec_adl(vec_adl),
        .vec_fetch(vec_fetch), .wr_inhibit(wr_inhibit), .ipc_inhibit(ipc_inhibit),
        .b_flag(b_flag), .set_i(set_i), .force_brk(force_brk), .nmi_pend(nmi_pend)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic noise;
        sync   = 1'($urandom_range(0, 1));
        brk_op = 1'($urandom_range(0, 1));
        irq_n  = 1'($urandom_range(0, 1));
        i_flag = 1'($urandom_range(0, 1));
    endtask

    // Expected outputs derived from the cycle-role table for a given source.
    task automatic check_outs(input string tag, input bit active, input int c, input int src,
                              input bit force_e, input bit pend_e);
        logic [18:0] exp_v, obs_v;
        logic [7:0]  adl;
        logic [2:0]  ce;
        bit vf, ipc, wr, bf, si;
        #1;
        vf  = active && c >= 5;
        adl = vf ? VEC_LO[src] + ((c == 6) ? 8'd1 : 8'd0) : 8'h00;
        ce  = active ? c[2:0] : 3'd0;
        ipc = active && c <= 1 && src != S_BRK;
        wr  = active && c >= 2 && c <= 4 && src == S_RST;
        bf  = active && c == 4 && src == S_BRK;
        si  = active && c == 5;
        exp_v = {active, ce, adl, vf, wr, ipc, bf, si, force_e, pend_e};
        obs_v = {svc_active, svc_cyc, vec_adl, vec_fetch, wr_inhibit, ipc_inhibit,
                 b_flag, set_i, force_brk, nmi_pend};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs_v, exp_v);
        end
    endtask

    // Walks one service sequence from first_cyc; nmi_n falls at edge_cyc (-1: never),
    // rdy drops for stall_len cycles before cycle stall_cyc, stops early at abort_cyc.
    task automatic run_service(input int start_src, input int first_cyc, input int edge_cyc,
                               input int stall_cyc, input int stall_len, input int abort_cyc);
        int src;
        src = start_src;
        for (int c = first_cyc; c <= 6; c++) begin
            if (c == stall_cyc) begin
                for (int s = 0; s < stall_len; s++) begin
                    rdy = 1'b0;
                    noise();
                    nmi_n = (edge_cyc >= 0 && c >= edge_cyc) ? 1'b0 : 1'b1;
                    check_outs($sformatf("stall s%0d c%0d", start_src, c), 1'b1, c, src, 1'b0, pend_m);
                    tick();
                end
            end
            rdy = 1'b1;
            noise();
            nmi_n = (edge_cyc >= 0 && c >= edge_cyc) ? 1'b0 : 1'b1;
            check_outs($sformatf("svc s%0d c%0d e%0d", start_src, c, edge_cyc), 1'b1, c, src, 1'b0, pend_m);
            if (c == abort_cyc)
                return;
            tick();
            if (c == 4 && pend_m && (src == S_IRQ || src == S_BRK))
                src = S_NMI;
            if (c == edge_cyc)
                pend_m = 1'b1;
            if (c == 6 && src == S_NMI)
                pend_m = (edge_cyc == 5 || edge_cyc == 6);
        end
        rdy = 1'b1; sync = 1'b0; brk_op = 1'b0;
        check_outs("idle after svc", 1'b0, 0, S_RST, 1'b0, pend_m);
    endtask

    initial begin
        bit take;
        int e, st, sl;

        // Reset hold, including a frozen cycle
        rst = 1'b1; rdy = 1'b1; sync = 1'b0; brk_op = 1'b0;
        irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b1;
        tick(); tick();
        rdy = 1'b0; nmi_n = 1'b0;
        check_outs("reset hold", 1'b1, 0, S_RST, 1'b0, 1'b0);
        tick();
        rdy = 1'b1; nmi_n = 1'b1;
        check_outs("reset hold2", 1'b1, 0, S_RST, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        check_outs("reset release", 1'b1, 0, S_RST, 1'b0, 1'b0);
        tick();
        run_service(S_RST, 0, -1, -1, 0, -1);

        // IRQ taken with I clear
        sync = 1'b1; irq_n = 1'b0; i_flag = 1'b0;
        check_outs("irq sync", 1'b0, 0, S_RST, 1'b1, pend_m);
        tick();
        run_service(S_IRQ, 0, -1, -1, 0, -1);

        // IRQ masked with I set
        sync = 1'b1; irq_n = 1'b0; i_flag = 1'b1;
        check_outs("irq masked", 1'b0, 0, S_RST, 1'b0, pend_m);
        tick();
        sync = 1'b0;
        check_outs("irq masked next", 1'b0, 0, S_RST, 1'b0, pend_m);

        // Plain BRK
        brk_op = 1'b1; irq_n = 1'b1;
        check_outs("brk op", 1'b0, 0, S_RST, 1'b0, pend_m);
        tick();
        run_service(S_BRK, 1, -1, -1, 0, -1);

        // BRK hijacked by an NMI edge in cycle 2
        brk_op = 1'b1;
        check_outs("brk op hj", 1'b0, 0, S_RST, 1'b0, pend_m);
        tick();
        run_service(S_BRK, 1, 2, -1, 0, -1);

        // IRQ stalled at cycle 3 with nmi_n falling during the stall
        sync = 1'b1; irq_n = 1'b0; i_flag = 1'b0; nmi_n = 1'b1;
        check_outs("irq sync stall", 1'b0, 0, S_RST, 1'b1, pend_m);
        tick();
        run_service(S_IRQ, 0, 3, 3, 3, -1);

        // NMI service with a second edge in cycle 5 stays pending
        nmi_n = 1'b1;
        check_outs("nmi arm", 1'b0, 0, S_RST, 1'b0, pend_m);
        tick();
        nmi_n = 1'b0;
        check_outs("nmi fall", 1'b0, 0, S_RST, 1'b0, pend_m);
        tick();
        pend_m = 1'b1;
        sync = 1'b1; irq_n = 1'b1;
        check_outs("nmi sync", 1'b0, 0, S_RST, 1'b1, pend_m);
        tick();
        run_service(S_NMI, 0, 5, -1, 0, -1);
        sync = 1'b1; irq_n = 1'b1;
        check_outs("nmi late sync", 1'b0, 0, S_RST, 1'b1, pend_m);
        tick();
        run_service(S_NMI, 0, -1, -1, 0, -1);

        // Abort an NMI service at cycle 4 with reset
        nmi_n = 1'b1;
        check_outs("abort arm", 1'b0, 0, S_RST, 1'b0, pend_m);
        tick();
        nmi_n = 1'b0;
        tick();
        pend_m = 1'b1;
        sync = 1'b1;
        check_outs("abort sync", 1'b0, 0, S_RST, 1'b1, pend_m);
        tick();
        run_service(S_NMI, 0, -1, -1, 0, 4);
        rst = 1'b1; nmi_n = 1'b1;
        tick();
        pend_m = 1'b0;
        check_outs("abort reset", 1'b1, 0, S_RST, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        run_service(S_RST, 0, -1, -1, 0, -1);

        // Randomized mix of IRQ/NMI takes, BRKs, stalls and NMI edges
        for (int it = 0; it < 40; it++) begin
            rdy = 1'b1; brk_op = 1'b0; sync = 1'b1;
            irq_n  = 1'($urandom_range(0, 1));
            i_flag = 1'($urandom_range(0, 1));
            take = pend_m || (!irq_n && !i_flag);
            check_outs($sformatf("rnd sync %0d", it), 1'b0, 0, S_RST, take, pend_m);
            tick();
            sync = 1'b0;
            st = ($urandom_range(0, 1) == 0) ? -1 : 6;
            sl = int'($urandom_range(1, 3));
            if (take) begin
                e = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 6));
                if (st >= 0) st = int'($urandom_range(0, 6));
                run_service(pend_m ? S_NMI : S_IRQ, 0, e, st, sl, -1);
            end else if ($urandom_range(0, 2) != 0) begin
                brk_op = 1'b1;
                check_outs($sformatf("rnd brk %0d", it), 1'b0, 0, S_RST, 1'b0, pend_m);
                tick();
                e = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(2, 6));
                if (st >= 0) st = int'($urandom_range(1, 6));
                run_service(S_BRK, 1, e, st, sl, -1);
            end else begin
                check_outs($sformatf("rnd idle %0d", it), 1'b0, 0, S_RST, 1'b0, pend_m);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_sched.md
INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  cycle enable; low freezes all state.
- sync  in  1  opcode-fetch cycle marker from the control word.
- brk_op  in  1  decoder pulse: BRK opcode decoded, valid on the cycle after sync.
- irq_n  in  1  level interrupt request, active low.
- nmi_n  in  1  edge interrupt request, falling-edge active.
- i_flag  in  1  current P.I bit.
- svc_active  out  1  service sequence in progress.
- svc_cyc  out  3  service cycle index 0..6.
- vec_adl  out  8  vector low address byte, valid during vector fetch.
- vec_fetch  out  1  current cycle reads a vector byte.
- wr_inhibit  out  1  stack pushes become reads (reset sequence).
- ipc_inhibit  out  1  suppress PC increment.
- b_flag  out  1  B bit value for the pushed P.
- set_i  out  1  set P.I this cycle.
- force_brk  out  1  replace the fetched opcode with 0x00.
- nmi_pend  out  1  NMI edge latched, not yet serviced.
REQ-002 Clock and reset SHALL be named clk and rst; reset SHALL be synchronous and active-high.

Function
REQ-003 States: RESET, IDLE, SERVICE; source register src ∈ {RST, NMI, IRQ, BRK}.
REQ-004 NMI edge detection SHALL work as follows:
- nmi_n is registered each enabled cycle.
- A registered 1 followed by a current 0 sets nmi_pend.
- nmi_pend clears at the end of service cycle 6 of a sequence whose final src=NMI.
REQ-005 irq_req SHALL equal (~irq_n & ~i_flag), evaluated combinationally at the sync cycle.
REQ-006 In IDLE with sync=1 and rdy=1, SHALL take an interrupt as follows:
- If nmi_pend=1 or irq_req=1: force_brk=1 this cycle.
- Next state SERVICE, svc_cyc=0.
- src=NMI if nmi_pend, else IRQ.
REQ-007 In IDLE with brk_op=1 and rdy=1 (no hardware take pending), the block SHALL enter SERVICE at svc_cyc=1 with src=BRK.
REQ-008 SERVICE SHALL advance svc_cyc by 1 per enabled cycle from 0 to 6, then return to IDLE.
REQ-009 rdy=0 SHALL hold state, svc_cyc, src and nmi_pend; nmi_n sampling is also frozen.
REQ-010 Cycle roles (svc_cyc): 0,1 opcode/dummy; 2 push PCH; 3 push PCL; 4 push P; 5 vector low; 6 vector high.
REQ-011 ipc_inhibit SHALL be 1 in cycles 0-1 for src ∈ {RST, NMI, IRQ}, and 0 for BRK.
REQ-012 b_flag SHALL be 1 in cycle 4 only when src=BRK, else 0.
REQ-013 wr_inhibit SHALL be 1 in cycles 2-4 only when src=RST.
REQ-014 vec_fetch SHALL be 1 in cycles 5-6; vec_adl SHALL be:
- NMI: 0xFA/0xFB.
- RST: 0xFC/0xFD.
- IRQ/BRK: 0xFE/0xFF.
- 0x00 when vec_fetch=0.
REQ-015 set_i SHALL pulse in cycle 5 for every src.
REQ-016 NMI hijack: if nmi_pend=1 at the start of cycle 4 and src ∈ {IRQ, BRK}, src SHALL become NMI from cycle 5.
- b_flag already pushed is unaffected.
REQ-017 An NMI edge arriving in cycles 5-6 SHALL remain pending and be taken at the next sync.
REQ-018 brk_op or sync during SERVICE SHALL be ignored.
REQ-019 svc_active SHALL be 1 in RESET and SERVICE.

Reset
REQ-020 While rst=1, the block SHALL hold these values:
- state=RESET, src=RST, svc_cyc=0, nmi_pend=0.
- Registered nmi_n=1.
- All outputs except svc_active=1 and ipc_inhibit=1 at 0.
REQ-021 On the first cycle with rst=0, state SHALL become SERVICE at svc_cyc=0, src=RST.
REQ-022 rst asserted mid-SERVICE SHALL abort the sequence and discard the pending NMI.

Verification
REQ-023 Reset sequence: release rst, rdy=1 -> 7 cycles; wr_inhibit=1 at cyc 2-4; vec_adl 0xFC then 0xFD; set_i at cyc 5; then IDLE.
REQ-024 IRQ: i_flag=0, irq_n=0 at sync -> force_brk=1; b_flag=0 at cyc 4; vec 0xFE/0xFF. Same with i_flag=1 -> no take.
REQ-025 BRK: brk_op pulse -> svc_cyc starts at 1; ipc_inhibit=0; b_flag=1 at cyc 4; vec 0xFE/0xFF.
REQ-026 Hijack: BRK service with nmi_n falling during cyc 2 -> vec 0xFA/0xFB; b_flag=1 at cyc 4; nmi_pend=0 after cyc 6.
REQ-027 Stall: rdy=0 for 3 cycles at cyc 3 -> svc_cyc holds 3; a nmi_n edge with rdy=0 is not latched until rdy=1.
REQ-028 Abort: rst=1 at cyc 4 of an NMI service -> nmi_pend=0; full RST sequence follows release.
